// File: rtl/iram_banked.sv
// rtl/iram_banked.sv - banked instruction-information RAM with bypassed multi-port reads
// Entries indexed by ROB id {pack, way}; tracks per-entry validity and live pack count.
module iram_banked #(
    parameter int WAYS      = 2,
    parameter int PACKS     = 16,
    parameter int RD_PORTS  = 2,
    parameter int PAYLOAD_W = 52,
    localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 0,
    localparam int PB  = $clog2(PACKS),
    localparam int IDW = PB + WB
) (
    input  logic                          cpu_clk_i,
    input  logic                          cpu_rst_ni,
    input  logic                          wr_valid_i,
    input  logic [PB-1:0]                 wr_pack_i,
    input  logic [WAYS-1:0]               wr_way_valid_i,
    input  logic [WAYS*PAYLOAD_W-1:0]     wr_data_i,
    input  logic                          free_valid_i,
    input  logic [PB-1:0]                 free_pack_i,
    input  logic                          flush_i,
    input  logic [RD_PORTS-1:0]           rd_req_i,
    input  logic [RD_PORTS*IDW-1:0]       rd_rob_i,
    output logic [RD_PORTS-1:0]           rd_valid_o,
    output logic [RD_PORTS-1:0]           rd_hit_o,
    output logic [RD_PORTS*PAYLOAD_W-1:0] rd_data_o,
    output logic [PB:0]                   live_packs_o,
    output logic                          rd_miss_o
);

    localparam int WBX = (WB > 0) ? WB : 1;

    logic [PAYLOAD_W-1:0]       mem [PACKS][WAYS];
    logic [PACKS-1:0][WAYS-1:0] valid_q;
    logic [PACKS-1:0][WAYS-1:0] valid_d;
    logic [PACKS-1:0]           pack_live;
    logic [PB:0]                live_q;
    logic                       write_en;
    logic                       live_inc;
    logic                       live_dec;
    logic [RD_PORTS-1:0]        rd_valid_d;
    logic [RD_PORTS-1:0]        hit_d;
    logic [RD_PORTS-1:0]        rd_valid_q;
    logic [RD_PORTS-1:0]        rd_hit_q;
    logic                       miss_q;

    assign write_en = wr_valid_i && (wr_way_valid_i != '0);

    // Free clears the slot before the write re-marks it: a same-cycle pair means reallocation.
    always_comb begin
        valid_d = valid_q;
        if (free_valid_i) begin
            valid_d[free_pack_i] = '0;
        end
        if (write_en) begin
            valid_d[wr_pack_i] = valid_d[wr_pack_i] | wr_way_valid_i;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    for (genvar k = 0; k < PACKS; k++) begin : g_live
        assign pack_live[k] = |valid_q[k];
    end

    assign live_inc = write_en && !pack_live[wr_pack_i];
    assign live_dec = free_valid_i && pack_live[free_pack_i]
                      && !(write_en && (wr_pack_i == free_pack_i));

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            valid_q <= '0;
            live_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (flush_i) begin
                live_q <= '0;
            end else if (live_inc && !live_dec) begin
                live_q <= live_q + (PB+1)'(1);
            end else if (live_dec && !live_inc) begin
                live_q <= live_q - (PB+1)'(1);
            end
        end
    end

    // Payload storage is deliberately unreset; validity alone decides visibility.
    always_ff @(posedge cpu_clk_i) begin
        for (int w = 0; w < WAYS; w++) begin
            if (write_en && !flush_i && wr_way_valid_i[WBX'(w)]) begin
                mem[wr_pack_i][WBX'(w)] <= wr_data_i[w*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign rd_valid_d = rd_req_i & {RD_PORTS{!flush_i}};

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [IDW-1:0]       rob;
        logic [PB-1:0]        pack;
        logic [WBX-1:0]       way;
        logic                 bypass;
        logic [PAYLOAD_W-1:0] data_d;
        logic [PAYLOAD_W-1:0] data_q;

        assign rob  = rd_rob_i[p*IDW +: IDW];
        assign pack = rob[IDW-1 -: PB];
        if (WB > 0) begin : g_way
            assign way = rob[WBX-1:0];
        end else begin : g_one
            assign way = '0;
        end

        // A same-cycle write wins; a same-cycle free alone still shows the old entry.
        assign bypass   = write_en && (wr_pack_i == pack) && wr_way_valid_i[way];
        assign hit_d[p] = bypass || valid_q[pack][way];
        assign data_d   = bypass ? wr_data_i[way*PAYLOAD_W +: PAYLOAD_W] : mem[pack][way];

        always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
            if (!cpu_rst_ni) begin
                data_q <= '0;
            end else if (rd_valid_d[p]) begin
                data_q <= data_d;
            end
        end

        assign rd_data_o[p*PAYLOAD_W +: PAYLOAD_W] = data_q;
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            rd_valid_q <= '0;
            rd_hit_q   <= '0;
            miss_q     <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= hit_d & rd_valid_d;
            miss_q     <= miss_q | (|(rd_valid_d & ~hit_d));
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign rd_hit_o     = rd_hit_q;
    assign live_packs_o = live_q;
    assign rd_miss_o    = miss_q;

endmodule
